// File: rtl/serial_loader.sv
// Serial-to-parallel 8-bit word loader feeding an 8-bit register (d/st).
// Define SERIAL_LOADER_PARITY_EN to accept and check a trailing even-parity bit.
module serial_loader #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] d,
    output logic       st,
    output logic       busy,
    output logic       err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] PARITY = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    logic [2:0] state;
    logic [2:0] cnt;
    logic [7:0] sr;
    logic [7:0] sr_next;
    logic [2:0] idx;
    logic [2:0] pos;
    logic       take;

    // Word position of the incoming bit; a new word always starts from an empty register.
    always_comb begin
        idx     = (state == IDLE) ? 3'd0 : cnt;
        pos     = (LSB_FIRST != 0) ? idx : 3'd7 - idx;
        sr_next = (state == IDLE) ? 8'h00 : sr;
        sr_next[pos] = in_bit;
    end

    assign in_ready = (state == IDLE) || (state == SHIFT) || (state == PARITY);
    assign take     = in_valid && in_ready && !abort;
    assign busy     = (state != IDLE);
    assign st       = (state == DONE);

`ifdef SERIAL_LOADER_PARITY_EN
    assign err = (state == ERR);
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sr    <= 8'h00;
            d     <= 8'h00;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= 3'd0;
            sr    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sr    <= sr_next;
                        cnt   <= 3'd1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (take) begin
                        if (cnt == 3'd7) begin
                            cnt <= 3'd0;
`ifdef SERIAL_LOADER_PARITY_EN
                            sr    <= sr_next;
                            state <= PARITY;
`else
                            d     <= sr_next;
                            sr    <= 8'h00;
                            state <= DONE;
`endif
                        end else begin
                            sr  <= sr_next;
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                PARITY: begin
`ifdef SERIAL_LOADER_PARITY_EN
                    if (take) begin
                        if ((^sr ^ in_bit) == 1'b0) begin
                            d     <= sr;
                            state <= DONE;
                        end else begin
                            state <= ERR;
                        end
                        sr <= 8'h00;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE, ERR: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter LSB_FIRST, default 1, meaning 1 = first accepted bit lands in d[0], 0 = first accepted bit lands in d[7].
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port in_bit  input  1  serial data bit.
REQ-005 SHALL have port in_valid  input  1  in_bit is offered this cycle.
REQ-006 SHALL have port in_ready  output  1  loader accepts a bit this cycle.
REQ-007 SHALL have port abort  input  1  synchronous discard of any partial word.
REQ-008 SHALL have port d  output  8  last completed word; feeds the 8-bit register data input.
REQ-009 SHALL have port st  output  1  one-cycle store strobe; feeds the 8-bit register store input.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port err  output  1  one-cycle parity-error pulse (tied 0 when parity is compiled out).

Function
REQ-012 SHALL implement states IDLE, SHIFT, PARITY, DONE, ERR.
REQ-013 Bit acceptance SHALL occur only on an edge where in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL be 1 in IDLE, SHIFT and PARITY, and 0 in DONE and ERR.
REQ-015 Bits offered while in_ready=0 SHALL be dropped without side effects.
REQ-016 IDLE: an accepted bit SHALL be stored as word bit 0, with bit counter set to 1 and the transition to SHIFT.
REQ-017 SHIFT: an accepted bit SHALL be stored at the counter position and the counter incremented; in_valid=0 SHALL hold all state, with gaps of any length allowed.
REQ-018 Acceptance of the 8th bit SHALL transition to DONE when parity is compiled out, or to PARITY when compiled in.
REQ-019 On entering DONE, d SHALL be loaded with the assembled word at the same edge; st SHALL be 1 for exactly the DONE cycle; DONE SHALL return to IDLE unconditionally.
REQ-020 Latency SHALL be: last data bit accepted at edge N, so st=1 and new d valid in cycle N+1.
REQ-021 d SHALL hold its value at all times except on entry to DONE.
REQ-022 abort=1 SHALL force IDLE at the next edge and clear the counter and shift register, with d unchanged and no st; abort SHALL have priority over in_valid, including on the 8th bit.
REQ-023 abort asserted in the DONE cycle SHALL NOT suppress the st already being driven.
REQ-024 A 9th bit offered while in DONE SHALL be ignored and SHALL NOT start a new word.
REQ-025 busy SHALL be combinational from state.

Reset
REQ-026 rst=1 SHALL asynchronously force state IDLE, counter 0, shift register 0x00, d=0x00, st=0, err=0, busy=0, in_ready=1.
REQ-027 Reset mid-word SHALL discard the partial word; the first accepted bit after rst deasserts SHALL be word bit 0.

Configuration
REQ-028 Macro SERIAL_LOADER_PARITY_EN SHALL select parity checking.
REQ-029 Defined: after 8 data bits, one even-parity bit SHALL be accepted in PARITY; if the XOR of the 8 data bits and the parity bit is 0, go to DONE; otherwise go to ERR.
REQ-030 Defined, ERR state: err=1 for one cycle, d unchanged, no st, then IDLE.
REQ-031 Undefined: PARITY and ERR SHALL be unreachable and err SHALL be constant 0; the word SHALL be 8 bits only.

Verification
REQ-032 LSB_FIRST=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> st=1 one cycle after the 8th bit, d=0xA5.
REQ-033 Same word with in_valid gaps of 0-3 cycles between bits -> identical d=0xA5 and single st pulse; busy high from the first bit through DONE.
REQ-034 Bits 0..4 accepted, then abort=1 -> IDLE next cycle, d keeps previous 0xA5, no st; next 8 bits 0xFF -> d=0xFF.
REQ-035 rst pulsed asynchronously after 3 bits -> d=0x00 and busy=0 immediately; a following 8-bit word 0x3C -> d=0x3C.
REQ-036 Parity compiled in, 0x0F followed by parity bit 0 -> st and d=0x0F; 0x0F followed by parity bit 1 -> err one-cycle pulse, d stays 0x0F from the prior word, no st.
REQ-037 in_valid held high continuously across two words -> the bit offered in the DONE cycle is dropped; the second word begins on the following cycle.
